// File: rtl/alu_arbiter_if.sv
// Request/response channels of both ALU requesters plus the shared-ALU port.
// master = requesters and ALU side, slave = the arbiter.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned OP_W = 4;

  logic             req0_valid;
  logic             req0_ready;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_err;

  logic             req1_valid;
  logic             req1_ready;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_err;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OP_W-1:0]  alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_err,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_err,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrate, register the
// winning operands, run the ALU for one cycle and hold the result until consumed.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned OP_W = 4;
  localparam logic [OP_W-1:0] LAST_LEGAL_OP = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [OP_W-1:0]  cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  logic             rsp0_valid;
  logic             rsp0_err;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp1_valid;
  logic             rsp1_err;
  logic [WIDTH-1:0] rsp1_result;

  logic             grant_valid;
  logic             grant_id;
  logic             op_legal;
  logic [WIDTH-1:0] exec_result;
  logic             owner_rsp_ready;

  // Grant only in IDLE; contention goes to the requester that did not win last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign op_legal        = (cap_op <= LAST_LEGAL_OP);
  assign exec_result     = op_legal ? bus.alu_result : '0;
  assign owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cap_op      <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp0_result <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_err    <= 1'b0;
      rsp1_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cap_op     <= grant_id ? bus.req1_op : bus.req0_op;
            cap_a      <= grant_id ? bus.req1_a  : bus.req0_a;
            cap_b      <= grant_id ? bus.req1_b  : bus.req0_b;
            owner      <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= exec_result;
            rsp1_err    <= ~op_legal;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= exec_result;
            rsp0_err    <= ~op_legal;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = grant_valid && !grant_id;
  assign bus.req1_ready  = grant_valid &&  grant_id;
  assign bus.rsp0_valid  = rsp0_valid;
  assign bus.rsp0_result = rsp0_result;
  assign bus.rsp0_err    = rsp0_err;
  assign bus.rsp1_valid  = rsp1_valid;
  assign bus.rsp1_result = rsp1_result;
  assign bus.rsp1_err    = rsp1_err;
  assign bus.alu_a       = cap_a;
  assign bus.alu_b       = cap_b;
  assign bus.alu_ctrl    = cap_op;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a round-robin and a fixed-priority instance,
// each with its own ALU model and expected-response queue.
module tb_alu_arbiter;
  typedef struct {
    bit          owner;
    logic [31:0] result;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_rr[$];
  exp_t q_fp[$];

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(32)) bus_rr ();
  alu_arbiter_if #(.WIDTH(32)) bus_fp ();

  alu_arbiter #(.WIDTH(32), .FIXED_PRIO(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
  alu_arbiter #(.WIDTH(32), .FIXED_PRIO(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

  // Reference ALU; illegal codes return a marker the arbiter must discard.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return a << b[4:0];
      4'h6:    return a >> b[4:0];
      4'h7:    return 32'($signed(a) >>> b[4:0]);
      4'h8:    return 32'($signed(a) < $signed(b));
      4'h9:    return 32'(a < b);
      4'hA:    return a;
      4'hB:    return b;
      4'hC:    return ~(a | b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus_rr.alu_result = alu_fn(bus_rr.alu_ctrl, bus_rr.alu_a, bus_rr.alu_b);
  assign bus_fp.alu_result = alu_fn(bus_fp.alu_ctrl, bus_fp.alu_a, bus_fp.alu_b);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endfunction

  function automatic void fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endfunction

  function automatic void pop_chk(input bit fp, input bit owner, input logic [31:0] res,
                                  input logic err);
    exp_t e;
    if (fp) begin
      if (q_fp.size() == 0) begin
        fail_msg($sformatf("fp_unexpected_rsp owner=%0d", owner));
        return;
      end
      e = q_fp.pop_front();
    end else begin
      if (q_rr.size() == 0) begin
        fail_msg($sformatf("rr_unexpected_rsp owner=%0d", owner));
        return;
      end
      e = q_rr.pop_front();
    end
    chk1(fp ? "fp_rsp_owner" : "rr_rsp_owner", owner, e.owner);
    chk(fp ? "fp_rsp_result" : "rr_rsp_result", res, e.result);
    chk1(fp ? "fp_rsp_err" : "rr_rsp_err", err, e.err);
  endfunction

  // Monitor: every response handshake is compared against the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_rr.rsp0_valid && bus_rr.rsp0_ready)
        pop_chk(1'b0, 1'b0, bus_rr.rsp0_result, bus_rr.rsp0_err);
      if (bus_rr.rsp1_valid && bus_rr.rsp1_ready)
        pop_chk(1'b0, 1'b1, bus_rr.rsp1_result, bus_rr.rsp1_err);
      if (bus_fp.rsp0_valid && bus_fp.rsp0_ready)
        pop_chk(1'b1, 1'b0, bus_fp.rsp0_result, bus_fp.rsp0_err);
      if (bus_fp.rsp1_valid && bus_fp.rsp1_ready)
        pop_chk(1'b1, 1'b1, bus_fp.rsp1_result, bus_fp.rsp1_err);
    end
  end

  task automatic idle_inputs();
    bus_rr.req0_valid = 1'b0; bus_rr.req0_op = 4'h0; bus_rr.req0_a = '0; bus_rr.req0_b = '0;
    bus_rr.req1_valid = 1'b0; bus_rr.req1_op = 4'h0; bus_rr.req1_a = '0; bus_rr.req1_b = '0;
    bus_rr.rsp0_ready = 1'b1; bus_rr.rsp1_ready = 1'b1;
    bus_fp.req0_valid = 1'b0; bus_fp.req0_op = 4'h0; bus_fp.req0_a = '0; bus_fp.req0_b = '0;
    bus_fp.req1_valid = 1'b0; bus_fp.req1_op = 4'h0; bus_fp.req1_a = '0; bus_fp.req1_b = '0;
    bus_fp.rsp0_ready = 1'b1; bus_fp.rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q_rr.size() == 0 && q_fp.size() == 0) return;
      @(negedge clk);
    end
    fail_msg($sformatf("drain_timeout rr=%0d fp=%0d", q_rr.size(), q_fp.size()));
    q_rr.delete();
    q_fp.delete();
  endtask

  // Single request on the round-robin instance; expectation queued at issue time.
  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic err);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    q_rr.push_back('{id, res, err});
    if (!id) begin
      bus_rr.req0_op = op; bus_rr.req0_a = a; bus_rr.req0_b = b; bus_rr.req0_valid = 1'b1;
    end else begin
      bus_rr.req1_op = op; bus_rr.req1_a = a; bus_rr.req1_b = b; bus_rr.req1_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? bus_rr.req1_ready : bus_rr.req0_ready;
    end
    if (!got) fail_msg($sformatf("issue_ready_timeout id=%0d", id));
    @(posedge clk);
    #1;
    bus_rr.req0_valid = 1'b0;
    bus_rr.req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    @(negedge clk);
    chk1("rst_rsp0_valid", bus_rr.rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", bus_rr.rsp1_valid, 1'b0);
    chk("rst_rsp0_result", bus_rr.rsp0_result, 32'h0);
    chk1("rst_rsp0_err", bus_rr.rsp0_err, 1'b0);
    chk1("rst_req0_ready", bus_rr.req0_ready, 1'b0);
    chk("rst_alu_a", bus_rr.alu_a, 32'h0);
    chk("rst_alu_ctrl", 32'(bus_rr.alu_ctrl), 32'h0);

    // Single op with cycle-exact latency
    @(posedge clk);
    #1;
    q_rr.push_back('{1'b0, 32'd12, 1'b0});
    bus_rr.req0_op = 4'h0; bus_rr.req0_a = 32'd5; bus_rr.req0_b = 32'd7; bus_rr.req0_valid = 1'b1;
    @(negedge clk);
    chk1("single_req0_ready_c0", bus_rr.req0_ready, 1'b1);
    chk1("single_req1_ready_c0", bus_rr.req1_ready, 1'b0);
    @(posedge clk);
    #1 bus_rr.req0_valid = 1'b0;
    @(negedge clk);
    chk1("single_rsp0_valid_c1", bus_rr.rsp0_valid, 1'b0);
    chk("single_alu_a", bus_rr.alu_a, 32'd5);
    chk("single_alu_b", bus_rr.alu_b, 32'd7);
    @(negedge clk);
    chk1("single_rsp0_valid_c2", bus_rr.rsp0_valid, 1'b1);
    chk("single_rsp0_result_c2", bus_rr.rsp0_result, 32'd12);
    chk1("single_rsp1_valid_c2", bus_rr.rsp1_valid, 1'b0);

    // Legal/illegal op-code boundary and an illegal op from requester 1
    issue(1'b0, 4'hC, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 4'hD, 32'd3, 32'd4, 32'h0, 1'b1);
    issue(1'b1, 4'hE, 32'd9, 32'd9, 32'h0, 1'b1);
    issue(1'b1, 4'h5, 32'd3, 32'd2, 32'd12, 1'b0);
    drain();
    chk("alu_hold_a", bus_rr.alu_a, 32'd3);
    chk("alu_hold_ctrl", 32'(bus_rr.alu_ctrl), 32'h5);

    // Round-robin contention: grants alternate 0,1,0,1
    do_reset();
    q_rr.push_back('{1'b0, 32'd7, 1'b0});
    q_rr.push_back('{1'b1, 32'd16, 1'b0});
    q_rr.push_back('{1'b0, 32'd7, 1'b0});
    q_rr.push_back('{1'b1, 32'd16, 1'b0});
    bus_rr.req0_op = 4'h1; bus_rr.req0_a = 32'd10; bus_rr.req0_b = 32'd3;
    bus_rr.req1_op = 4'h5; bus_rr.req1_a = 32'd1;  bus_rr.req1_b = 32'd4;
    bus_rr.req0_valid = 1'b1; bus_rr.req1_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
    drain();

    // Fixed priority: requester 0 wins every time
    do_reset();
    for (int i = 0; i < 4; i++) q_fp.push_back('{1'b0, 32'd7, 1'b0});
    bus_fp.req0_op = 4'h1; bus_fp.req0_a = 32'd10; bus_fp.req0_b = 32'd3;
    bus_fp.req1_op = 4'h5; bus_fp.req1_a = 32'd1;  bus_fp.req1_b = 32'd4;
    bus_fp.req0_valid = 1'b1; bus_fp.req1_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk1("fp_req1_ready", bus_fp.req1_ready, 1'b0);
      @(posedge clk);
    end
    #1 bus_fp.req0_valid = 1'b0; bus_fp.req1_valid = 1'b0;
    drain();

    // Response backpressure on requester 0 with requester 1 waiting
    do_reset();
    q_rr.push_back('{1'b0, 32'd12, 1'b0});
    q_rr.push_back('{1'b1, 32'd5, 1'b0});
    bus_rr.rsp0_ready = 1'b0;
    bus_rr.req0_op = 4'h0; bus_rr.req0_a = 32'd5; bus_rr.req0_b = 32'd7;
    bus_rr.req1_op = 4'h4; bus_rr.req1_a = 32'd6; bus_rr.req1_b = 32'd3;
    bus_rr.req0_valid = 1'b1; bus_rr.req1_valid = 1'b1;
    @(negedge clk);
    chk1("bp_req0_ready_c0", bus_rr.req0_ready, 1'b1);
    @(posedge clk);
    #1 bus_rr.req0_valid = 1'b0;
    @(negedge clk);
    chk1("bp_req1_ready_exec", bus_rr.req1_ready, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk1("bp_rsp0_valid_hold", bus_rr.rsp0_valid, 1'b1);
      chk("bp_rsp0_result_hold", bus_rr.rsp0_result, 32'd12);
      chk1("bp_rsp0_err_hold", bus_rr.rsp0_err, 1'b0);
      chk1("bp_req1_ready_hold", bus_rr.req1_ready, 1'b0);
    end
    @(posedge clk);
    #1 bus_rr.rsp0_ready = 1'b1;
    @(negedge clk);
    chk1("bp_req1_ready_hs", bus_rr.req1_ready, 1'b0);
    @(negedge clk);
    chk1("bp_req1_ready_after", bus_rr.req1_ready, 1'b1);
    @(posedge clk);
    #1 bus_rr.req1_valid = 1'b0;
    drain();

    // Reset during EXEC discards the op and restores requester-0 priority
    @(posedge clk);
    #1;
    bus_rr.req0_op = 4'h0; bus_rr.req0_a = 32'd1; bus_rr.req0_b = 32'd2; bus_rr.req0_valid = 1'b1;
    @(posedge clk);
    #1 bus_rr.req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_rsp0_valid", bus_rr.rsp0_valid, 1'b0);
    chk("mid_rst_alu_a", bus_rr.alu_a, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("post_rst_rsp0_valid", bus_rr.rsp0_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    q_rr.push_back('{1'b0, 32'd42, 1'b0});
    bus_rr.req0_op = 4'h0; bus_rr.req0_a = 32'd20; bus_rr.req0_b = 32'd22;
    bus_rr.req1_op = 4'h1; bus_rr.req1_a = 32'd9;  bus_rr.req1_b = 32'd4;
    bus_rr.req0_valid = 1'b1; bus_rr.req1_valid = 1'b1;
    @(negedge clk);
    chk1("post_rst_req0_ready", bus_rr.req0_ready, 1'b1);
    chk1("post_rst_req1_ready", bus_rr.req1_ready, 1'b0);
    @(posedge clk);
    #1 bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    chk("final_rr_queue", 32'(q_rr.size()), 32'h0);
    chk("final_fp_queue", 32'(q_fp.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
